// File: rtl/loop_recorder_pkg.sv
// Shared state encodings and width helpers for the banked loop recorder.
package loop_recorder_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REC  = 2'd1,
        R_OVD  = 2'd2
    } rec_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_OUT  = 2'd2
    } scan_state_t;

    function automatic int calc_bw(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/loop_step_ram.sv
// Step store for all banks: write port A, registered read port B (old data on collision).
module loop_step_ram
    import loop_recorder_pkg::*;
#(
    parameter int KEYS  = 16,
    parameter int BANKS = 8,
    parameter int DEPTH = 256,
    localparam int ABITS = calc_bw(BANKS) + calc_aw(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [KEYS-1:0]  wr_data,
    input  logic             rd_en,
    input  logic [ABITS-1:0] rd_addr,
    output logic [KEYS-1:0]  rd_data
);

    logic [KEYS-1:0] mem [BANKS*DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/loop_recorder_banked.sv
// Multi-bank keypad loop recorder with per-bank length/playhead and OR-mixed playback.
// Optional overdub onto non-empty banks is enabled by defining OVERDUB_EN.
module loop_recorder_banked
    import loop_recorder_pkg::*;
#(
    parameter int KEYS  = 16,
    parameter int BANKS = 8,
    parameter int DEPTH = 256,
    localparam int BW = calc_bw(BANKS),
    localparam int AW = calc_aw(DEPTH),
    localparam int CW = calc_cw(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             beat_tick,
    input  logic [KEYS-1:0]  keypad_vector,
    input  logic             record_switch,
    input  logic [BW-1:0]    record_bank,
    input  logic [BANKS-1:0] loop_switches,
    output logic [KEYS-1:0]  looper_vector,
    output logic             output_ready,
    output logic             recording,
    output logic [BW-1:0]    output_bank_number,
    output logic [CW-1:0]    output_memory_count,
    output logic             record_full,
    output logic             overrun
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [BW:0]   K_END   = (BW+1)'(BANKS);

    rec_state_t      rec_q, rec_d;
    scan_state_t     scan_q, scan_d;
    logic            sw_q;
    logic [BW-1:0]   bank_q, bank_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic [CW-1:0]   len_q [BANKS];
    logic [CW-1:0]   len_d [BANKS];
    logic [AW-1:0]   ph_q [BANKS];
    logic [AW-1:0]   ph_d [BANKS];
    logic [BW:0]     k_q, k_d;
    logic [KEYS-1:0] acc_q, acc_d;
    logic            rd_valid_q, rd_valid_d;
    logic [BW-1:0]   rd_bank_q, rd_bank_d;
    logic [KEYS-1:0] looper_q, looper_d;
    logic            ready_q, ready_d;
    logic            overrun_q, overrun_d;
`ifdef OVERDUB_EN
    logic [KEYS-1:0] ovd_keys_q, ovd_keys_d;
`endif

    logic            rise, fall;
    logic [KEYS-1:0] mix;
    logic            wr_en, rd_en;
    logic [BW+AW-1:0] wr_addr, rd_addr;
    logic [KEYS-1:0] wr_data, rd_data;

    assign rise = record_switch & ~sw_q;
    assign fall = ~record_switch & sw_q;

    loop_step_ram #(.KEYS(KEYS), .BANKS(BANKS), .DEPTH(DEPTH)) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Scan and record FSMs share one block so a record commit can override a playhead step.
    always_comb begin
        rec_d      = rec_q;
        scan_d     = scan_q;
        bank_d     = bank_q;
        count_d    = count_q;
        full_d     = 1'b0;
        len_d      = len_q;
        ph_d       = ph_q;
        k_d        = k_q;
        acc_d      = acc_q;
        rd_valid_d = 1'b0;
        rd_bank_d  = rd_bank_q;
        looper_d   = looper_q;
        ready_d    = 1'b0;
        overrun_d  = overrun_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        mix        = '0;
`ifdef OVERDUB_EN
        ovd_keys_d = ovd_keys_q;
`endif

        if (rd_valid_q && len_q[rd_bank_q] != '0 && loop_switches[rd_bank_q] &&
            !(rec_q == R_REC && bank_q == rd_bank_q))
            mix = rd_data;
`ifdef OVERDUB_EN
        if (rd_valid_q && rec_q == R_OVD && bank_q == rd_bank_q) begin
            wr_en   = 1'b1;
            wr_addr = {bank_q, ph_q[bank_q]};
            wr_data = rd_data | ovd_keys_q;
            if (loop_switches[rd_bank_q]) mix = rd_data | ovd_keys_q;
        end
`endif

        if (beat_tick && scan_q != S_IDLE) overrun_d = 1'b1;

        case (scan_q)
            S_IDLE: begin
                if (beat_tick) begin
                    scan_d = S_READ;
                    k_d    = '0;
                    acc_d  = '0;
`ifdef OVERDUB_EN
                    ovd_keys_d = keypad_vector;
`endif
                end
            end
            S_READ: begin
                acc_d = acc_q | mix;
                if (k_q < K_END) begin
                    rd_en      = 1'b1;
                    rd_addr    = {k_q[BW-1:0], ph_q[k_q[BW-1:0]]};
                    rd_valid_d = 1'b1;
                    rd_bank_d  = k_q[BW-1:0];
                    k_d        = k_q + 1'b1;
                end else begin
                    scan_d   = S_OUT;
                    looper_d = acc_q | mix;
                    ready_d  = 1'b1;
                end
            end
            S_OUT: begin
                for (int b = 0; b < BANKS; b++) begin
                    if (len_q[b] != '0)
                        ph_d[b] = (CW'(ph_q[b]) + CW'(1) == len_q[b]) ? '0 : ph_q[b] + 1'b1;
                end
                scan_d = S_IDLE;
            end
            default: scan_d = S_IDLE;
        endcase

        case (rec_q)
            R_IDLE: begin
                if (rise) begin
                    bank_d  = record_bank;
                    count_d = '0;
`ifdef OVERDUB_EN
                    if (len_q[record_bank] != '0) begin
                        rec_d = R_OVD;
                    end else begin
                        rec_d = R_REC;
                        len_d[record_bank] = '0;
                    end
`else
                    rec_d = R_REC;
                    len_d[record_bank] = '0;
`endif
                end
            end
            R_REC: begin
                if (beat_tick) begin
                    wr_en   = 1'b1;
                    wr_addr = {bank_q, count_q[AW-1:0]};
                    wr_data = keypad_vector;
                    count_d = count_q + 1'b1;
                end
                if (count_d == DEPTH_C) begin
                    full_d        = 1'b1;
                    len_d[bank_q] = DEPTH_C;
                    ph_d[bank_q]  = '0;
                    rec_d         = R_IDLE;
                end else if (fall) begin
                    len_d[bank_q] = count_d;
                    ph_d[bank_q]  = '0;
                    rec_d         = R_IDLE;
                end
            end
            R_OVD: begin
                if (fall) rec_d = R_IDLE;
            end
            default: rec_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rec_q      <= R_IDLE;
            scan_q     <= S_IDLE;
            sw_q       <= 1'b0;
            bank_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            k_q        <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
            looper_q   <= '0;
            ready_q    <= 1'b0;
            overrun_q  <= 1'b0;
            for (int b = 0; b < BANKS; b++) begin
                len_q[b] <= '0;
                ph_q[b]  <= '0;
            end
`ifdef OVERDUB_EN
            ovd_keys_q <= '0;
`endif
        end else begin
            rec_q      <= rec_d;
            scan_q     <= scan_d;
            sw_q       <= record_switch;
            bank_q     <= bank_d;
            count_q    <= count_d;
            full_q     <= full_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
            rd_bank_q  <= rd_bank_d;
            looper_q   <= looper_d;
            ready_q    <= ready_d;
            overrun_q  <= overrun_d;
            len_q      <= len_d;
            ph_q       <= ph_d;
`ifdef OVERDUB_EN
            ovd_keys_q <= ovd_keys_d;
`endif
        end
    end

    assign looper_vector       = looper_q;
    assign output_ready        = ready_q;
    assign recording           = (rec_q != R_IDLE);
    assign output_bank_number  = bank_q;
    assign output_memory_count = count_q;
    assign record_full         = full_q;
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_loop_recorder_banked.sv
// Directed, table-driven bench for loop_recorder_banked (default build and DEPTH=4 copy).
module tb_loop_recorder_banked;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        beat_tick = 1'b0;
    logic [15:0] keypad_vector = '0;
    logic        record_switch = 1'b0;
    logic [2:0]  record_bank = '0;
    logic [7:0]  loop_switches = '0;

    logic [15:0] looper_vector, looper_vector4;
    logic        output_ready, output_ready4;
    logic        recording, recording4;
    logic [2:0]  output_bank_number, output_bank_number4;
    logic [8:0]  output_memory_count;
    logic [2:0]  output_memory_count4;
    logic        record_full, record_full4;
    logic        overrun, overrun4;

    int compared = 0;
    int mismatched = 0;
    int lastLatency = 0;
    logic lastReady4 = 1'b0;
    logic readyAfter = 1'b0;
    int fullPulses = 0;
    int fullPulses4 = 0;

    loop_recorder_banked #(.KEYS(16), .BANKS(8), .DEPTH(256)) u_dut (
        .clock(clock), .reset(reset), .beat_tick(beat_tick), .keypad_vector(keypad_vector),
        .record_switch(record_switch), .record_bank(record_bank), .loop_switches(loop_switches),
        .looper_vector(looper_vector), .output_ready(output_ready), .recording(recording),
        .output_bank_number(output_bank_number), .output_memory_count(output_memory_count),
        .record_full(record_full), .overrun(overrun)
    );

    loop_recorder_banked #(.KEYS(16), .BANKS(8), .DEPTH(4)) u_dut4 (
        .clock(clock), .reset(reset), .beat_tick(beat_tick), .keypad_vector(keypad_vector),
        .record_switch(record_switch), .record_bank(record_bank), .loop_switches(loop_switches),
        .looper_vector(looper_vector4), .output_ready(output_ready4), .recording(recording4),
        .output_bank_number(output_bank_number4), .output_memory_count(output_memory_count4),
        .record_full(record_full4), .overrun(overrun4)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (record_full)  fullPulses  <= fullPulses + 1;
        if (record_full4) fullPulses4 <= fullPulses4 + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [7:0]  sw;
        logic [15:0] exp;
        logic [15:0] exp4;
        bit          chk4;
    } vec_t;

    vec_t vecs [21];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        beat_tick = 1'b0;
        record_switch = 1'b0;
        keypad_vector = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // One beat: pulse beat_tick, wait (bounded) for output_ready, then let the scan go idle.
    task automatic applyStimulus(input logic [15:0] keys, output logic [15:0] got, output logic [15:0] got4);
        int waits;
        @(negedge clock);
        keypad_vector = keys;
        beat_tick = 1'b1;
        @(negedge clock);
        beat_tick = 1'b0;
        waits = 0;
        while (!output_ready && waits < 40) begin
            @(negedge clock);
            waits++;
        end
        if (!output_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
        got = looper_vector;
        got4 = looper_vector4;
        lastReady4 = output_ready4;
        lastLatency = waits;
        @(negedge clock);
        readyAfter = output_ready;
        @(negedge clock);
    endtask

    task automatic recordBank(input logic [2:0] bank, input int n, input logic [15:0] keys [6],
                              output logic recMid, output logic [8:0] countMid);
        logic [15:0] g, g4;
        @(negedge clock);
        record_bank = bank;
        record_switch = 1'b1;
        @(negedge clock);
        for (int i = 0; i < n; i++) applyStimulus(keys[i], g, g4);
        recMid = recording;
        countMid = output_memory_count;
        record_switch = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic runVectors(input int first, input int last);
        logic [15:0] g, g4;
        for (int i = first; i <= last; i++) begin
            loop_switches = vecs[i].sw;
            applyStimulus(16'h0000, g, g4);
            checkOutput($sformatf("vec%0d_looper", i), {16'h0, g}, {16'h0, vecs[i].exp});
            if (vecs[i].chk4) checkOutput($sformatf("vec%0d_looper4", i), {16'h0, g4}, {16'h0, vecs[i].exp4});
        end
    endtask

    initial begin
        logic [15:0] ks [6];
        logic [15:0] g, g4;
        logic        recMid;
        logic [8:0]  countMid;
        int          readyCount;
        int          base, base4;

        vecs[0]  = '{8'h04, 16'h0001, 16'h0000, 1'b0};
        vecs[1]  = '{8'h04, 16'h0002, 16'h0000, 1'b0};
        vecs[2]  = '{8'h04, 16'h0004, 16'h0000, 1'b0};
        vecs[3]  = '{8'h04, 16'h0001, 16'h0000, 1'b0};
        vecs[4]  = '{8'h03, 16'h0014, 16'h0000, 1'b0};
        vecs[5]  = '{8'h03, 16'h0021, 16'h0000, 1'b0};
        vecs[6]  = '{8'h03, 16'h0012, 16'h0000, 1'b0};
        vecs[7]  = '{8'h03, 16'h0024, 16'h0000, 1'b0};
        vecs[8]  = '{8'h03, 16'h0011, 16'h0000, 1'b0};
        vecs[9]  = '{8'h03, 16'h0022, 16'h0000, 1'b0};
        vecs[10] = '{8'h01, 16'h0010, 16'h0000, 1'b0};
        vecs[11] = '{8'h02, 16'h0001, 16'h0000, 1'b0};
        vecs[12] = '{8'h00, 16'h0000, 16'h0000, 1'b0};
        vecs[13] = '{8'h03, 16'h0024, 16'h0000, 1'b0};
        vecs[14] = '{8'h08, 16'h0001, 16'h0008, 1'b1};
        vecs[15] = '{8'h08, 16'h0002, 16'h0001, 1'b1};
        vecs[16] = '{8'h08, 16'h0004, 16'h0002, 1'b1};
        vecs[17] = '{8'h08, 16'h0008, 16'h0004, 1'b1};
        vecs[18] = '{8'h04, 16'h0101, 16'h0000, 1'b0};
        vecs[19] = '{8'h04, 16'h0102, 16'h0000, 1'b0};
        vecs[20] = '{8'h04, 16'h0104, 16'h0000, 1'b0};

        $display("[TB] reset state and scan latency");
        doReset();
        checkOutput("rst_looper", {16'h0, looper_vector}, 32'h0);
        checkOutput("rst_ready", {31'h0, output_ready}, 32'h0);
        checkOutput("rst_recording", {31'h0, recording}, 32'h0);
        checkOutput("rst_bank", {29'h0, output_bank_number}, 32'h0);
        checkOutput("rst_count", {23'h0, output_memory_count}, 32'h0);
        checkOutput("rst_full", {31'h0, record_full}, 32'h0);
        checkOutput("rst_overrun", {31'h0, overrun}, 32'h0);
        applyStimulus(16'h0000, g, g4);
        checkOutput("first_latency", lastLatency, 32'd9);
        checkOutput("first_looper", {16'h0, g}, 32'h0);
        checkOutput("ready_one_cycle", {31'h0, readyAfter}, 32'h0);

        $display("[TB] single bank record and playback");
        loop_switches = 8'h00;
        ks = '{16'h0001, 16'h0002, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
        recordBank(3'd2, 3, ks, recMid, countMid);
        checkOutput("b2_rec_mid", {31'h0, recMid}, 32'h1);
        checkOutput("b2_count_mid", {23'h0, countMid}, 32'd3);
        checkOutput("b2_count", {23'h0, output_memory_count}, 32'd3);
        checkOutput("b2_bank", {29'h0, output_bank_number}, 32'd2);
        checkOutput("b2_recording", {31'h0, recording}, 32'h0);
        runVectors(0, 3);

        $display("[TB] two bank mix and phase alignment");
        doReset();
        loop_switches = 8'h00;
        ks = '{16'h0001, 16'h0002, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
        recordBank(3'd1, 3, ks, recMid, countMid);
        ks = '{16'h0010, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        recordBank(3'd0, 2, ks, recMid, countMid);
        checkOutput("b0_count", {23'h0, output_memory_count}, 32'd2);
        runVectors(4, 13);

        $display("[TB] reset in the middle of a record");
        loop_switches = 8'h00;
        @(negedge clock);
        record_bank = 3'd5;
        record_switch = 1'b1;
        @(negedge clock);
        applyStimulus(16'h0040, g, g4);
        applyStimulus(16'h0080, g, g4);
        checkOutput("midrec_recording", {31'h0, recording}, 32'h1);
        checkOutput("midrec_count", {23'h0, output_memory_count}, 32'd2);
        doReset();
        checkOutput("postrst_recording", {31'h0, recording}, 32'h0);
        checkOutput("postrst_count", {23'h0, output_memory_count}, 32'd0);
        loop_switches = 8'hFF;
        applyStimulus(16'h0000, g, g4);
        checkOutput("postrst_looper", {16'h0, g}, 32'h0);

        $display("[TB] overrun on closely spaced beats");
        doReset();
        @(negedge clock);
        beat_tick = 1'b1;
        @(negedge clock);
        beat_tick = 1'b0;
        @(negedge clock);
        @(negedge clock);
        beat_tick = 1'b1;
        @(negedge clock);
        beat_tick = 1'b0;
        readyCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (output_ready) readyCount++;
        end
        checkOutput("overrun_ready_count", readyCount, 32'd1);
        checkOutput("overrun_set", {31'h0, overrun}, 32'h1);
        applyStimulus(16'h0000, g, g4);
        checkOutput("overrun_sticky", {31'h0, overrun}, 32'h1);
        doReset();
        checkOutput("overrun_cleared", {31'h0, overrun}, 32'h0);

        $display("[TB] auto-stop at depth (DEPTH=4 copy)");
        loop_switches = 8'h00;
        base = fullPulses;
        base4 = fullPulses4;
        ks = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020};
        recordBank(3'd3, 6, ks, recMid, countMid);
        checkOutput("d4_full_pulses", fullPulses4 - base4, 32'd1);
        checkOutput("d256_full_pulses", fullPulses - base, 32'd0);
        checkOutput("d4_recording", {31'h0, recording4}, 32'h0);
        checkOutput("d4_count", {29'h0, output_memory_count4}, 32'd4);
        checkOutput("d4_bank", {29'h0, output_bank_number4}, 32'd3);
        checkOutput("d4_overrun", {31'h0, overrun4}, 32'h0);
        checkOutput("d256_count", {23'h0, countMid}, 32'd6);
        runVectors(14, 17);
        checkOutput("d4_ready", {31'h0, lastReady4}, 32'h1);

`ifdef OVERDUB_EN
        $display("[TB] overdub onto bank 2");
        doReset();
        loop_switches = 8'h04;
        ks = '{16'h0001, 16'h0002, 16'h0004, 16'h0000, 16'h0000, 16'h0000};
        recordBank(3'd2, 3, ks, recMid, countMid);
        ks = '{16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000};
        recordBank(3'd2, 3, ks, recMid, countMid);
        checkOutput("ovd_rec_mid", {31'h0, recMid}, 32'h1);
        checkOutput("ovd_full_never", {31'h0, record_full}, 32'h0);
        runVectors(18, 20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/loop_recorder_banked.md
Name: loop_recorder_banked

Overview:
Parametrised multi-bank successor to the Lab4 recorder. It captures one keypad_vector snapshot per beat into per-bank loops held in a simple dual-port step RAM, replacing the flat output_memory vector. On each beat it scans every enabled bank, ORs the current steps together and presents the mix on looper_vector. Each bank has its own loop length and playhead.

Parameters:
KEYS, 16, width of keypad_vector and looper_vector
BANKS, 8, number of loop banks (>=2)
DEPTH, 256, max steps per bank (power of 2)
Derived localparams: BW=$clog2(BANKS), AW=$clog2(DEPTH), CW=$clog2(DEPTH+1).

Ports:
clock  in  1  single system clock; all logic on posedge
reset  in  1  synchronous, active-high
beat_tick  in  1  one-cycle beat strobe in the clock domain
keypad_vector  in  KEYS  live key state
record_switch  in  1  level; rise starts record, fall stops it
record_bank  in  BW  bank to record; sampled on record_switch rise
loop_switches  in  BANKS  per-bank playback enable
looper_vector  out  KEYS  mixed playback step
output_ready  out  1  one-cycle pulse when looper_vector updates
recording  out  1  high while a record is active
output_bank_number  out  BW  bank being recorded (last latched value)
output_memory_count  out  CW  steps written so far in the recording bank
record_full  out  1  one-cycle pulse on auto-stop at DEPTH
overrun  out  1  sticky; beat_tick arrived while a scan was busy

Behaviour:
- Reset: all outputs 0. All bank lengths len[b] and playheads ph[b] are 0. Both FSMs go idle. RAM contents are don't-care, because len=0 masks them.
- Record FSM, states R_IDLE and R_REC. A rising edge of record_switch is detected against a registered copy.
- R_IDLE -> R_REC on the rise: latch record_bank into output_bank_number, set count=0, len[bank]=0, recording=1.
- R_REC, on beat_tick: write keypad_vector to address {bank,count[AW-1:0]}, then count++.
- R_REC, count reaches DEPTH: pulse record_full, commit len=DEPTH, ph=0, go to R_IDLE.
- R_REC, falling edge of record_switch: commit len=count, ph=0, go to R_IDLE. A 0-step record leaves the bank empty.
- Rise and fall in the same cycle cannot occur, because record_switch is a single bit.
- Scan FSM, states S_IDLE, S_READ, S_OUT. beat_tick at cycle T (scan idle) enters S_READ at T+1.
- S_READ: cycle T+1+k issues a read of {k,ph[k]} for k=0..BANKS-1. Read latency is one cycle.
- A bank's data is ORed into the accumulator only if loop_switches[k]=1, len[k]!=0, and the bank is not currently recording.
- S_OUT at T+BANKS+2: looper_vector<=acc and output_ready=1 for one cycle.
- Also in S_OUT: every bank with len>0 advances its playhead, ph=(ph+1==len)?0:ph+1. Then return to S_IDLE.
- Beat spacing: beat_tick while the scan is not idle is ignored for playback and sets overrun. That tick still drives a record write.
- Ports: record writes use RAM port A and scans use port B, so there is no contention. A same-address read and write returns old data.
- Disabled banks keep advancing their playheads, so they stay phase-aligned when re-enabled.
- Reset mid-record: the record is discarded and all banks are cleared.

Optional Feature:
OVERDUB_EN.
- Defined: a rise on a bank with len>0 enters R_OVD instead of R_REC, and len is kept.
- R_OVD scan: that bank's read data is ORed with keypad_vector latched at the tick. The result is written back to {bank,ph} in the cycle the data returns, and is also mixed to output.
- Ends on fall of record_switch. len is unchanged and record_full never fires.
- Undefined: every record replaces the bank as above.

Decomposition:
- loop_recorder_pkg: record and scan state enums, and CW/AW/BW helper functions.
- Sub-module loop_step_ram: BANKS*DEPTH x KEYS, simple dual-port, write port A, registered read port B.

Test Plan:
- Reset (KEYS=16, BANKS=8, DEPTH=256) -> all outputs 0; a beat gives output_ready at T+10 with looper_vector=0.
- Record bank 2 over 3 ticks with keypad 0x0001/0x0002/0x0004, then release; loop_switches=8'h04 -> count=3, subsequent beats give 0x0001, 0x0002, 0x0004, 0x0001...
- Bank0 {0x0010,0x0020} and bank1 {0x0001,0x0002,0x0004}, loop_switches=8'h03 -> 0x0011, 0x0022, 0x0014, 0x0021, 0x0012, 0x0024.
- DEPTH=4, hold record for 6 ticks -> record_full pulses after the 4th write, len=4, recording=0, later ticks write nothing.
- BANKS=8, two ticks 3 cycles apart -> one output_ready, overrun=1 until reset.
- Reset during R_REC after 2 writes -> len all 0, recording=0. With OVERDUB_EN: overdub 0x0100 onto bank 2 {1,2,4} -> 0x0101, 0x0102, 0x0104.
